lab3_keypad_scan: RTL and testbench

LAB3_KEYPAD_SCAN -- requirements
Module: lab3_keypad_scan

---
 rtl/lab3_keypad_pkg.sv | 19 +
 rtl/lab3_key_decode.sv | 14 +
 rtl/lab3_keypad_scan.sv | 131 +++++++++++++
 tb/tb_lab3_keypad_scan.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_keypad_pkg.sv
// Shared types and the key-map table for the 4x4 keypad scanner.
package lab3_keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Indexed [row][col].
    localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

endpackage

// File: rtl/lab3_key_decode.sv
// Combinational row/column index to hex key code lookup.
module lab3_key_decode
    import lab3_keypad_pkg::*;
(
    input  logic [1:0] row_i,
    input  logic [1:0] col_i,
    output logic [3:0] code_o
);

    always_comb begin
        code_o = KEY_MAP[row_i][col_i];
    end

endmodule

// File: rtl/lab3_keypad_scan.sv
// 4x4 keypad scanner: column scan, press/release debounce, one-cycle key_valid pulse.
module lab3_keypad_scan
    import lab3_keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);

    state_e            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    logic [3:0]        key_q, key_d;
    logic              valid_q, valid_d;

    logic [1:0]        low_row;
    logic              any_low;
    logic              row_bit;
    logic [3:0]        map_code;

    lab3_key_decode u_decode (
        .row_i  (row_q),
        .col_i  (col_q),
        .code_o (map_code)
    );

    always_comb begin
        any_low = ~&rows;
        row_bit = rows[row_q];
        if (!rows[0])      low_row = 2'd0;
        else if (!rows[1]) low_row = 2'd1;
        else if (!rows[2]) low_row = 2'd2;
        else               low_row = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        valid_d = 1'b0;
        case (state_q)
            SCAN: begin
                if (any_low) begin
                    row_d   = low_row;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end else if (div_q >= DIV_LAST) begin
                    col_d = col_q + 2'd1;
                    div_d = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (row_bit) begin
                    col_d   = col_q + 2'd1;
                    div_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q >= DB_MAX) begin
                    key_d   = map_code;
                    valid_d = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (row_bit) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Any re-closure restarts the release window rather than re-arming a press.
                if (!row_bit) begin
                    cnt_d = '0;
                end else if (cnt_q >= DB_MAX) begin
                    col_d   = col_q + 2'd1;
                    div_d   = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            col_q   <= '0;
            row_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        cols      = ~(4'b0001 << col_q);
        key       = key_q;
        key_valid = valid_q;
    end

endmodule

// File: tb/tb_lab3_keypad_scan.sv
// Directed bench for lab3_keypad_scan with a behavioural 4x4 keypad model.
module tb_lab3_keypad_scan;

    localparam int unsigned SDIV = 4;
    localparam int unsigned DB   = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;

    logic [15:0] pressed;
    int          total;
    int          bad;
    int          pulse_cnt;

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [16];

    lab3_keypad_scan #(
        .SCAN_DIV        (SDIV),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .int_osc   (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: pressed bit r*4+c pulls row r low while column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    initial pulse_cnt = 0;
    always @(posedge clk) if (key_valid) pulse_cnt <= pulse_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presses keys in mask and returns cycles from the first low sample to key_valid (0 on timeout).
    task automatic accept(input logic [15:0] mask, output int lat);
        bit found;
        found = 0;
        lat   = 0;
        pressed = pressed | mask;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (rows != 4'hF) found = 1;
        end
        if (found) begin
            tick();
            found = 0;
            for (int i = 0; i < 40 && !found; i++) begin
                tick();
                lat++;
                if (key_valid) found = 1;
            end
            if (!found) lat = 0;
        end
    endtask

    task automatic release_all();
        pressed = '0;
        repeat (2*DB + 8) tick();
    endtask

    initial begin
        int         lat;
        int         p0;
        logic [3:0] prev;
        logic [3:0] ec;
        logic [15:0] m;

        total   = 0;
        bad     = 0;
        pressed = '0;
        reset   = 1'b0;

        vecs[0]  = '{2'd0, 2'd0, 4'h1};  vecs[1]  = '{2'd0, 2'd1, 4'h2};
        vecs[2]  = '{2'd0, 2'd2, 4'h3};  vecs[3]  = '{2'd0, 2'd3, 4'hA};
        vecs[4]  = '{2'd1, 2'd0, 4'h4};  vecs[5]  = '{2'd1, 2'd1, 4'h5};
        vecs[6]  = '{2'd1, 2'd2, 4'h6};  vecs[7]  = '{2'd1, 2'd3, 4'hB};
        vecs[8]  = '{2'd2, 2'd0, 4'h7};  vecs[9]  = '{2'd2, 2'd1, 4'h8};
        vecs[10] = '{2'd2, 2'd2, 4'h9};  vecs[11] = '{2'd2, 2'd3, 4'hC};
        vecs[12] = '{2'd3, 2'd0, 4'hE};  vecs[13] = '{2'd3, 2'd1, 4'h0};
        vecs[14] = '{2'd3, 2'd2, 4'hF};  vecs[15] = '{2'd3, 2'd3, 4'hD};

        // Reset values and first column advance exactly SCAN_DIV cycles after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst cols", 32'(cols), 32'h0E);
        check("rst key", 32'(key), 32'h0);
        check("rst kv", 32'(key_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("pre-advance cols", 32'(cols), 32'h0E);
        end
        tick();
        check("first advance cols", 32'(cols), 32'h0D);

        // Row1/col2 press: key 6, latency DB+1, single pulse.
        p0 = pulse_cnt;
        accept(16'h0040, lat);
        check("r1c2 latency", 32'(lat), 32'(DB + 1));
        check("r1c2 key", 32'(key), 32'h6);
        tick();
        check("r1c2 pulse width", 32'(key_valid), 32'h0);
        release_all();
        check("r1c2 pulses", 32'(pulse_cnt - p0), 32'h1);

        // Full key map.
        for (int i = 0; i < 16; i++) begin
            m  = 16'h0001 << (vecs[i].r * 4 + vecs[i].c);
            ec = 4'b0001 << vecs[i].c;
            ec = ~ec;
            accept(m, lat);
            check("map latency", 32'(lat), 32'(DB + 1));
            check("map key", 32'(key), 32'(vecs[i].exp));
            check("map cols frozen", 32'(cols), 32'(ec));
            tick();
            check("map pulse width", 32'(key_valid), 32'h0);
            release_all();
        end

        // Bounce: row0/col1 low for 5 samples then high.
        prev = key;
        p0   = pulse_cnt;
        pressed = 16'h0002;
        for (int i = 0; i < 40 && rows == 4'hF; i++) @(negedge clk);
        tick();
        repeat (4) tick();
        pressed = '0;
        tick();
        check("bounce next col", 32'(cols), 32'h0B);
        repeat (30) tick();
        check("bounce pulses", 32'(pulse_cnt - p0), 32'h0);
        check("bounce key kept", 32'(key), 32'(prev));

        // Long hold with release re-bounce, then a fresh press.
        p0 = pulse_cnt;
        accept(16'h0100, lat);
        check("hold key", 32'(key), 32'h7);
        repeat (100) tick();
        check("hold cols frozen", 32'(cols), 32'h0E);
        pressed = '0;
        repeat (4) tick();
        pressed = 16'h0100;
        repeat (3) tick();
        pressed = '0;
        repeat (30) tick();
        check("rebounce pulses", 32'(pulse_cnt - p0), 32'h1);
        check("rebounce key", 32'(key), 32'h7);
        accept(16'h8000, lat);
        check("fresh latency", 32'(lat), 32'(DB + 1));
        check("fresh key", 32'(key), 32'hD);
        release_all();
        check("fresh pulses", 32'(pulse_cnt - p0), 32'h2);

        // Two rows in column 0: lowest row wins; row2 ignored while held/releasing.
        p0 = pulse_cnt;
        accept(16'h0101, lat);
        check("dual key", 32'(key), 32'h1);
        pressed = 16'h0100;
        repeat (DB + 1) tick();
        check("dual release pending", 32'(cols), 32'h0E);
        tick();
        check("dual release exit", 32'(cols), 32'h0D);
        pressed = '0;
        repeat (20) tick();
        check("dual pulses", 32'(pulse_cnt - p0), 32'h1);

        // Asynchronous reset mid-debounce at count 5.
        p0 = pulse_cnt;
        pressed = 16'h0020;
        for (int i = 0; i < 40 && rows == 4'hF; i++) @(negedge clk);
        tick();
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        check("async rst cols", 32'(cols), 32'h0E);
        check("async rst key", 32'(key), 32'h0);
        check("async rst kv", 32'(key_valid), 32'h0);
        repeat (3) tick();
        pressed = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) tick();
        check("async rst pulses", 32'(pulse_cnt - p0), 32'h0);
        check("async rst key kept", 32'(key), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
